// File: rtl/scramble_move_generator_pkg.sv
// Shared cube-game definitions: FSM states, move-code layout and LFSR polynomial.
// The cube-state block decodes moves with the same field positions.
package scramble_move_generator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    OFFER = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MOVE_W    = 4;
  localparam int NUM_FACES = 6;
  localparam int NUM_CODES = 12;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam int MOVE_DIR_BIT  = 0;
  localparam int MOVE_FACE_LSB = 1;
  localparam int MOVE_FACE_MSB = 3;

  // Same face, opposite direction.
  function automatic logic [MOVE_W-1:0] inverse_move(input logic [MOVE_W-1:0] code);
    return code ^ MOVE_W'(1 << MOVE_DIR_BIT);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/scramble_move_generator_if.sv
// Request, move handshake and status signals between the scrambler (master)
// and the game control / cube-state logic (slave).
interface scramble_move_generator_if;
  import scramble_move_generator_pkg::*;

  logic              RandomPlease;
  logic              move_ready;
  logic              move_valid;
  logic [MOVE_W-1:0] move_code;
  logic              scramble_busy;
  logic              scramble_done;

  modport master (
    input  RandomPlease,
    input  move_ready,
    output move_valid,
    output move_code,
    output scramble_busy,
    output scramble_done
  );

  modport slave (
    output RandomPlease,
    output move_ready,
    input  move_valid,
    input  move_code,
    input  scramble_busy,
    input  scramble_done
  );

endinterface

// File: rtl/scramble_move_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift, mask LFSR_MASK), advancing every cycle.
// q exposes the low OUT_W bits; SEED must be non-zero.
module scramble_move_generator_lfsr16
  import scramble_move_generator_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] q
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign q = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/scramble_move_generator.sv
// Emits a burst of NUM_MOVES random cube moves per rising edge of RandomPlease; a move is
// offered one or more draw cycles after the request and held on move_valid until move_ready.
module scramble_move_generator
  import scramble_move_generator_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 31,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  scramble_move_generator_if.master bus
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_MOVES - 1);

  state_t            r_state;
  logic              r_rp;
  logic [5:0]        r_count;
  logic [MOVE_W-1:0] r_prev_code;
  logic              r_prev_valid;
  logic              r_move_valid;
  logic [MOVE_W-1:0] r_move_code;
  logic              r_busy;
  logic              r_done;

  logic [MOVE_W-1:0] w_cand;
  logic              w_request;
  logic              w_reject;
  logic              w_handshake;
  logic              w_last;

  scramble_move_generator_lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (MOVE_W)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_cand)
  );

  assign w_request   = bus.RandomPlease & ~r_rp;
  // Codes 12..15 are unused, and undoing the previous move would waste a scramble step.
  assign w_reject    = (w_cand >= MOVE_W'(NUM_CODES)) ||
                       (r_prev_valid && (w_cand == inverse_move(r_prev_code)));
  assign w_handshake = r_move_valid & bus.move_ready;
  assign w_last      = (r_count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rp         <= 1'b0;
      r_count      <= '0;
      r_prev_code  <= '0;
      r_prev_valid <= 1'b0;
      r_move_valid <= 1'b0;
      r_move_code  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_rp   <= bus.RandomPlease;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_request) begin
            r_state      <= DRAW;
            r_count      <= '0;
            r_prev_valid <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        DRAW: begin
          if (!w_reject) begin
            r_move_code  <= w_cand;
            r_move_valid <= 1'b1;
            r_state      <= OFFER;
          end
        end
        OFFER: begin
          if (w_handshake) begin
            r_move_valid <= 1'b0;
            r_prev_code  <= r_move_code;
            r_prev_valid <= 1'b1;
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_count <= r_count + 6'd1;
              r_state <= DRAW;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.move_valid    = r_move_valid;
  assign bus.move_code     = r_move_code;
  assign bus.scramble_busy = r_busy;
  assign bus.scramble_done = r_done;

endmodule

// File: tb/tb_scramble_move_generator.sv
// Scramble generator bench: random handshake timing, moves predicted from an LFSR
// reference and the draw/reject rules; a second instance covers a one-move burst.
module tb_scramble_move_generator;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] m_lfsr;
  logic [3:0]  codes1[$];
  int          done1 = 0;
  logic [3:0]  first_exp;

  scramble_move_generator_if bus ();
  scramble_move_generator_if bus1 ();

  scramble_move_generator #(.NUM_MOVES(31), .LFSR_SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  scramble_move_generator #(.NUM_MOVES(1), .LFSR_SEED(SEED)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  assign bus1.RandomPlease = bus.RandomPlease;
  assign bus1.move_ready   = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);

  // One-move instance: with ready tied high each valid cycle is one handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus1.move_valid) codes1.push_back(bus1.move_code);
      if (bus1.scramble_done) done1++;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First acceptable code reachable from LFSR value l0, and how many rejects precede it.
  function automatic void predict(input logic [15:0] l0, input logic [3:0] prev, input bit pv,
                                  output logic [3:0] code, output int nrej);
    logic [15:0] l;
    l = l0;
    nrej = 0;
    while ((l[3:0] >= 4'd12 || (pv && l[3:0] == (prev ^ 4'd1))) && nrej < 1000) begin
      l = lfsr_step(l);
      nrej++;
    end
    code = l[3:0];
  endfunction

  task automatic run_burst(input bit stall, input int retrig_at, input int abort_at,
                           input bit hold_req);
    logic [3:0] exp_code;
    logic [3:0] prev;
    bit         pv;
    int         nrej;
    int         nwait;
    int         base1;
    int         based;
    prev  = 4'd0;
    pv    = 1'b0;
    base1 = codes1.size();
    based = done1;
    bus.RandomPlease = 1'b1;
    @(negedge clk);
    if (!hold_req) bus.RandomPlease = 1'b0;
    for (int m = 0; m < 31; m++) begin
      chk_eq("draw_busy", bus.scramble_busy, 1);
      predict(m_lfsr, prev, pv, exp_code, nrej);
      if (m == 0) first_exp = exp_code;
      for (int k = 0; k <= nrej; k++) begin
        chk_eq("draw_vld", bus.move_valid, 0);
        bus.move_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk_eq("offer_vld", bus.move_valid, 1);
      chk_eq("offer_code", bus.move_code, exp_code);
      chk_eq("code_range", bus.move_code < 4'd12, 1);
      chk_eq("not_inverse", pv && (bus.move_code == (prev ^ 4'd1)), 0);
      if (m == retrig_at) bus.RandomPlease = 1'b1;
      if (m == abort_at) begin
        reset = 1'b1;
        bus.move_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk_eq("abort_vld", bus.move_valid, 0);
        chk_eq("abort_code", bus.move_code, 0);
        chk_eq("abort_busy", bus.scramble_busy, 0);
        chk_eq("abort_done", bus.scramble_done, 0);
        chk_eq("abort_lfsr", dut.u_lfsr.r_lfsr, m_lfsr);
        bus.RandomPlease = 1'b0;
        @(negedge clk);
        chk_eq("abort_idle", bus.scramble_busy, 0);
        return;
      end
      nwait = (stall && m == 3) ? 10 : $urandom_range(0, 2);
      bus.move_ready = 1'b0;
      for (int s = 0; s < nwait; s++) begin
        @(negedge clk);
        chk_eq("stall_vld", bus.move_valid, 1);
        chk_eq("stall_code", bus.move_code, exp_code);
      end
      bus.move_ready = 1'b1;
      @(negedge clk);
      prev = exp_code;
      pv   = 1'b1;
    end
    chk_eq("done_pulse", bus.scramble_done, 1);
    chk_eq("done_busy", bus.scramble_busy, 0);
    chk_eq("done_vld", bus.move_valid, 0);
    @(negedge clk);
    chk_eq("done_clear", bus.scramble_done, 0);
    chk_eq("after_busy", bus.scramble_busy, 0);
    if (hold_req) begin
      repeat (5) begin
        @(negedge clk);
        chk_eq("held_no_retrig", bus.scramble_busy, 0);
      end
    end
    bus.RandomPlease = 1'b0;
    bus.move_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("one_move_count", codes1.size() - base1, (retrig_at >= 0) ? 2 : 1);
    chk_eq("one_move_done", done1 - based, (retrig_at >= 0) ? 2 : 1);
    if (codes1.size() > base1) chk_eq("one_move_code", codes1[base1], first_exp);
  endtask

  initial begin
    bus.RandomPlease = 1'b0;
    bus.move_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("rst_vld", bus.move_valid, 0);
    chk_eq("rst_code", bus.move_code, 0);
    chk_eq("rst_busy", bus.scramble_busy, 0);
    chk_eq("rst_done", bus.scramble_done, 0);
    chk_eq("rst_lfsr", dut.u_lfsr.r_lfsr, SEED);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk_eq("idle_vld", bus.move_valid, 0);
      chk_eq("idle_busy", bus.scramble_busy, 0);
      chk_eq("idle_lfsr", dut.u_lfsr.r_lfsr, m_lfsr);
    end
    run_burst(1'b1, -1, -1, 1'b0);
    repeat ($urandom_range(2, 20)) @(negedge clk);
    run_burst(1'b0, 5, -1, 1'b0);
    repeat ($urandom_range(2, 20)) @(negedge clk);
    run_burst(1'b0, -1, -1, 1'b1);
    repeat ($urandom_range(2, 20)) @(negedge clk);
    run_burst(1'b0, -1, 12, 1'b0);
    run_burst(1'b0, -1, -1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scramble_move_generator.md
# scramble_move_generator

Consumes the scramble request from the shuffle/solve state block and produces a finite burst of pseudo-random cube moves for the downstream cube-state register. A free-running 16-bit LFSR supplies entropy; candidate codes that are out of range or that would undo the previous move are rejected and redrawn. Each accepted move is offered on a valid/ready handshake, and the block reports busy and done status back to the game control logic.

## Interface
- NUM_MOVES, 31, moves per scramble burst; legal range 1..63.
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be non-zero.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- RandomPlease  in  1  scramble request level from the shuffle/solve state block.
- move_ready  in  1  downstream accepts the offered move this cycle.
- move_valid  out  1  move_code is valid and held.
- move_code  out  4  move index 0..11: face = code[3:1], direction = code[0] (0 = CW, 1 = CCW).
- scramble_busy  out  1  high from request acceptance until the last move is accepted.
- scramble_done  out  1  one-cycle pulse after the final handshake.

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Shifts right every cycle in all states, including IDLE, so button timing adds entropy.
- Request detection: the block registers RandomPlease. A request is the rising edge of RandomPlease (current high, registered value low), seen in IDLE only. Edges in any other state are ignored.
- States:
  - IDLE: no activity.
  - DRAW: candidate = lfsr[3:0]. Reject the candidate if it is ≥ 12. Also reject it if prev_valid is set and candidate == prev_code ^ 4'b0001 (the inverse of the previous move). On reject, stay in DRAW; the LFSR has already advanced. On accept, latch move_code = candidate, then go to OFFER.
  - OFFER: move_valid = 1 and move_code holds stable until move_ready. On the handshake:
    - prev_code ← move_code and prev_valid ← 1.
    - If count == NUM_MOVES-1, go to DONE; otherwise count++ and go to DRAW.
  - DONE: scramble_done = 1 for one cycle, then go to IDLE.
- IDLE → DRAW on a request. The same transition sets count ← 0 and prev_valid ← 0.
- Counter: 6 bits, unsigned, compared against NUM_MOVES-1. The counter never wraps.
- Reset (any state, including mid-burst):
  - State ← IDLE and lfsr ← LFSR_SEED.
  - count, prev_code and prev_valid ← 0; the registered RandomPlease ← 0.
  - All outputs ← 0.
  - A move pending in OFFER is dropped.
- scramble_busy = 1 in DRAW and OFFER, 0 in IDLE and DONE.

## Timing
- RandomPlease rises in cycle N → edge detected in N → DRAW in N+1 → earliest move_valid in N+2.
- DRAW takes one cycle per draw attempt. Expected rejection rate is 25–31%, and there is no hard bound on consecutive rejects.
- A handshake completes in any cycle where move_valid && move_ready; move_ready may stay high permanently.
- Minimum spacing between accepted moves: 2 cycles (OFFER, then DRAW, then OFFER).
- move_valid never drops without a handshake, except on reset.
- scramble_done is asserted in the cycle after the final handshake.
- A new request is accepted no earlier than the cycle after DONE, and only on a fresh rising edge. A level held high through DONE does not retrigger.
- Reset values: move_valid = 0, move_code = 0, scramble_busy = 0, scramble_done = 0.

## Structure
- Shared game package holds:
  - the state enum (IDLE, DRAW, OFFER, DONE);
  - MOVE_W = 4, NUM_FACES = 6, NUM_CODES = 12;
  - LFSR_MASK = 16'hB400;
  - the move-code face/direction field positions, so the cube-state block decodes identically.
- One sub-module is natural: lfsr16, with ports clk, reset, seed parameter and q. It is reusable by other random features.
- FSM, counter, edge detect and reject logic stay in the top module.

## Test plan
- Reset, then hold RandomPlease low for 100 cycles → move_valid = 0, scramble_busy = 0, lfsr ≠ 0 in every cycle.
- Pulse RandomPlease with move_ready = 1 throughout and NUM_MOVES = 31 → exactly 31 handshakes, all codes in 0..11. No code equals the previous code ^ 1. One scramble_done pulse follows, and scramble_busy is 0 one cycle later.
- move_ready low for 10 cycles while move_valid is high → move_code is constant across all 10 cycles and the count does not advance.
- Second RandomPlease edge mid-burst (after move 5) → ignored; the total stays at 31 moves.
- Reset asserted while in OFFER at move 12 → next cycle all outputs are 0 and the state is IDLE. A new request then yields the full 31 moves, and the first move is not inverse-checked.
- Fixed seed 16'hACE1 with a request at a fixed cycle → the move sequence matches the golden model exactly (deterministic replay); NUM_MOVES = 1 yields one move then scramble_done.
